// File: rtl/dcache_pkg.sv
// Shared constants and the cacheability rule for the data cache.
package dcache_pkg;

    localparam logic        HIT            = 1'b1;
    localparam logic        MISS           = 1'b0;
    localparam int          DCACHE_IDX_W   = 6;
    localparam logic [31:0] DCACHE_IO_BASE = 32'h0003_0000;
    localparam logic [31:0] ZERO_WORD      = 32'h0000_0000;
    localparam logic        WRITE_ENABLE   = 1'b1;

    // Word-aligned, nonzero, and below the memory-mapped I/O window.
    function automatic logic is_cacheable(input logic [31:0] addr,
                                          input logic [31:0] io_base);
        return (addr[1:0] == 2'b00) && (addr != 32'h0) && (addr < io_base);
    endfunction

endpackage

// File: rtl/dcache_line_store.sv
// Valid/tag/data arrays: one write port (fill, snoop clear, reset clear) and one read port.
module dcache_line_store
    import dcache_pkg::*;
#(
    parameter int NUM_LINES = 64,
    parameter int IDX_W     = $clog2(NUM_LINES),
    parameter int TAG_W     = 30 - IDX_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             fill_en_i,
    input  logic [IDX_W-1:0] fill_idx_i,
    input  logic [TAG_W-1:0] fill_tag_i,
    input  logic [31:0]      fill_data_i,
    input  logic             snoop_en_i,
    input  logic [IDX_W-1:0] snoop_idx_i,
    input  logic [TAG_W-1:0] snoop_tag_i,
    input  logic [IDX_W-1:0] rd_idx_i,
    output logic             rd_valid_o,
    output logic [TAG_W-1:0] rd_tag_o,
    output logic [31:0]      rd_data_o
);

    logic [NUM_LINES-1:0] valid_q;
    logic [NUM_LINES-1:0] valid_d;
    logic [TAG_W-1:0]     tag_q  [NUM_LINES];
    logic [31:0]          data_q [NUM_LINES];
    logic                 snoop_match;

    assign snoop_match = snoop_en_i && valid_q[snoop_idx_i] &&
                         (tag_q[snoop_idx_i] == snoop_tag_i);

    // The fill is applied after the snoop clear so a same-index fill wins.
    always_comb begin
        valid_d = valid_q;
        if (snoop_match) valid_d[snoop_idx_i] = 1'b0;
        if (fill_en_i)   valid_d[fill_idx_i]  = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) valid_q <= '0;
        else     valid_q <= valid_d;
    end

    // NOTE: tag/data need no reset; a line is only read through its valid bit.
    always_ff @(posedge clk) begin
        if (!rst && fill_en_i) begin
            tag_q[fill_idx_i]  <= fill_tag_i;
            data_q[fill_idx_i] <= fill_data_i;
        end
    end

    assign rd_valid_o = valid_q[rd_idx_i];
    assign rd_tag_o   = tag_q[rd_idx_i];
    assign rd_data_o  = data_q[rd_idx_i];

endmodule

// File: rtl/dcache.sv
// Direct-mapped write-through word cache for the MEM stage, with byte-store snoop invalidation.
module dcache
    import dcache_pkg::*;
#(
    parameter int          NUM_LINES = 64,
    parameter logic [31:0] IO_BASE   = DCACHE_IO_BASE
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        we_i,
    input  logic [31:0] waddr_i,
    input  logic [31:0] wdata_i,
    input  logic [31:0] raddr_i,
    input  logic        snoop_wr_i,
    input  logic [31:0] snoop_a_i,
    output logic        hit_o,
    output logic [31:0] data_o
);

    localparam int IDX_W = $clog2(NUM_LINES);
    localparam int TAG_W = 30 - IDX_W;

    logic             fill_en;
    logic             rd_valid;
    logic [TAG_W-1:0] rd_tag;
    logic [31:0]      rd_data;
    logic             lookup_hit;

    assign fill_en = (we_i == WRITE_ENABLE) && is_cacheable(waddr_i, IO_BASE);

    // Snoop uses the word containing the byte; only cacheable lines can ever match.
    dcache_line_store #(
        .NUM_LINES (NUM_LINES),
        .IDX_W     (IDX_W),
        .TAG_W     (TAG_W)
    ) u_line_store (
        .clk         (clk),
        .rst         (rst),
        .fill_en_i   (fill_en),
        .fill_idx_i  (waddr_i[IDX_W+1:2]),
        .fill_tag_i  (waddr_i[31:IDX_W+2]),
        .fill_data_i (wdata_i),
        .snoop_en_i  (snoop_wr_i),
        .snoop_idx_i (snoop_a_i[IDX_W+1:2]),
        .snoop_tag_i (snoop_a_i[31:IDX_W+2]),
        .rd_idx_i    (raddr_i[IDX_W+1:2]),
        .rd_valid_o  (rd_valid),
        .rd_tag_o    (rd_tag),
        .rd_data_o   (rd_data)
    );

    // Reset gating keeps the outputs quiet before the valid bits clear at the reset edge.
    assign lookup_hit = !rst && is_cacheable(raddr_i, IO_BASE) && rd_valid &&
                        (rd_tag == raddr_i[31:IDX_W+2]);

    assign hit_o  = lookup_hit ? HIT : MISS;
    assign data_o = lookup_hit ? rd_data : ZERO_WORD;

endmodule

// File: tb/tb_dcache.sv
// Directed self-checking bench for dcache.
module tb_dcache;

    logic        clk;
    logic        rst;
    logic        we_i;
    logic [31:0] waddr_i;
    logic [31:0] wdata_i;
    logic [31:0] raddr_i;
    logic        snoop_wr_i;
    logic [31:0] snoop_a_i;
    logic        hit_o;
    logic [31:0] data_o;

    int total;
    int bad;

    dcache dut (
        .clk        (clk),
        .rst        (rst),
        .we_i       (we_i),
        .waddr_i    (waddr_i),
        .wdata_i    (wdata_i),
        .raddr_i    (raddr_i),
        .snoop_wr_i (snoop_wr_i),
        .snoop_a_i  (snoop_a_i),
        .hit_o      (hit_o),
        .data_o     (data_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change on the falling edge; the rising edge in between commits them.
    task automatic fill(input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        we_i = 1'b1; waddr_i = a; wdata_i = d;
        @(negedge clk);
        we_i = 1'b0;
    endtask

    task automatic snoop(input logic [31:0] a);
        @(negedge clk);
        snoop_wr_i = 1'b1; snoop_a_i = a;
        @(negedge clk);
        snoop_wr_i = 1'b0;
    endtask

    task automatic lookup(input logic [31:0] a);
        @(negedge clk);
        raddr_i = a;
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; we_i = 1'b0; waddr_i = '0; wdata_i = '0;
        raddr_i = '0; snoop_wr_i = 1'b0; snoop_a_i = '0;
        repeat (2) @(negedge clk);
        lookup(32'h1000);
        total++;
        if (hit_o !== 1'b0 || data_o !== 32'h0) begin
            bad++; $display("FAIL reset_held: hit=%b data=%h want hit=0 data=0", hit_o, data_o);
        end
        @(negedge clk); rst = 1'b0;
        lookup(32'h1000);
        total++;
        if (hit_o !== 1'b0 || data_o !== 32'h0) begin
            bad++; $display("FAIL reset_miss: hit=%b data=%h want hit=0 data=0", hit_o, data_o);
        end
    endtask

    task automatic test_fill_hit();
        fill(32'h1000, 32'hDEADBEEF);
        lookup(32'h1000);
        total++;
        if (hit_o !== 1'b1 || data_o !== 32'hDEADBEEF) begin
            bad++; $display("FAIL fill_hit: hit=%b data=%h want hit=1 data=deadbeef", hit_o, data_o);
        end
        lookup(32'h1100);
        total++;
        if (hit_o !== 1'b0 || data_o !== 32'h0) begin
            bad++; $display("FAIL other_tag_miss: hit=%b data=%h want hit=0 data=0", hit_o, data_o);
        end
    endtask

    task automatic test_eviction();
        fill(32'h1000, 32'hDEADBEEF);
        fill(32'h1100, 32'h11223344);
        lookup(32'h1000);
        total++;
        if (hit_o !== 1'b0 || data_o !== 32'h0) begin
            bad++; $display("FAIL evicted_miss: hit=%b data=%h want hit=0 data=0", hit_o, data_o);
        end
        lookup(32'h1100);
        total++;
        if (hit_o !== 1'b1 || data_o !== 32'h11223344) begin
            bad++; $display("FAIL evictor_hit: hit=%b data=%h want hit=1 data=11223344", hit_o, data_o);
        end
    endtask

    task automatic test_snoop();
        fill(32'h2000, 32'hA5A5_5A5A);
        snoop(32'h2100);
        lookup(32'h2000);
        total++;
        if (hit_o !== 1'b1 || data_o !== 32'hA5A5_5A5A) begin
            bad++; $display("FAIL snoop_other_tag: hit=%b data=%h want hit=1 data=a5a55a5a", hit_o, data_o);
        end
        snoop(32'h30000);
        lookup(32'h2000);
        total++;
        if (hit_o !== 1'b1 || data_o !== 32'hA5A5_5A5A) begin
            bad++; $display("FAIL snoop_io_same_idx: hit=%b data=%h want hit=1 data=a5a55a5a", hit_o, data_o);
        end
        snoop(32'h2002);
        lookup(32'h2000);
        total++;
        if (hit_o !== 1'b0 || data_o !== 32'h0) begin
            bad++; $display("FAIL snoop_invalidate: hit=%b data=%h want hit=0 data=0", hit_o, data_o);
        end
    endtask

    task automatic test_fill_snoop_same_edge();
        @(negedge clk);
        we_i = 1'b1; waddr_i = 32'h2000; wdata_i = 32'hCAFEF00D;
        snoop_wr_i = 1'b1; snoop_a_i = 32'h2003;
        @(negedge clk);
        we_i = 1'b0; snoop_wr_i = 1'b0;
        lookup(32'h2000);
        total++;
        if (hit_o !== 1'b1 || data_o !== 32'hCAFEF00D) begin
            bad++; $display("FAIL fill_beats_snoop: hit=%b data=%h want hit=1 data=cafef00d", hit_o, data_o);
        end
    endtask

    task automatic test_noncacheable();
        logic [31:0] addrs [3];
        addrs[0] = 32'h2001; addrs[1] = 32'h0; addrs[2] = 32'h30004;
        for (int i = 0; i < 3; i++) begin
            fill(addrs[i], 32'h5555_0000 + i);
            lookup(addrs[i]);
            total++;
            if (hit_o !== 1'b0 || data_o !== 32'h0) begin
                bad++; $display("FAIL noncacheable_%0d: addr=%h hit=%b data=%h want hit=0 data=0",
                                i, addrs[i], hit_o, data_o);
            end
        end
        lookup(32'h2000);
        total++;
        if (hit_o !== 1'b1 || data_o !== 32'hCAFEF00D) begin
            bad++; $display("FAIL noncacheable_keeps_line: hit=%b data=%h want hit=1 data=cafef00d", hit_o, data_o);
        end
        fill(32'h2FFFC, 32'h0BAD_CAFE);
        lookup(32'h2FFFC);
        total++;
        if (hit_o !== 1'b1 || data_o !== 32'h0BAD_CAFE) begin
            bad++; $display("FAIL last_cacheable_word: hit=%b data=%h want hit=1 data=0badcafe", hit_o, data_o);
        end
    endtask

    task automatic test_back_to_back();
        @(negedge clk);
        we_i = 1'b1; waddr_i = 32'h4000; wdata_i = 32'h0000_0001;
        @(negedge clk);
        waddr_i = 32'h4004; wdata_i = 32'h0000_0002;
        @(negedge clk);
        waddr_i = 32'h4008; wdata_i = 32'h0000_0003;
        @(negedge clk);
        we_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            lookup(32'h4000 + 32'(4 * i));
            total++;
            if (hit_o !== 1'b1 || data_o !== 32'(i + 1)) begin
                bad++; $display("FAIL back_to_back_%0d: hit=%b data=%h want hit=1 data=%h",
                                i, hit_o, data_o, 32'(i + 1));
            end
        end
    endtask

    task automatic test_reset_mid();
        fill(32'h3000, 32'h1234_5678);
        lookup(32'h3000);
        total++;
        if (hit_o !== 1'b1 || data_o !== 32'h1234_5678) begin
            bad++; $display("FAIL pre_reset_hit: hit=%b data=%h want hit=1 data=12345678", hit_o, data_o);
        end
        // Fill and snoop on the reset edge must both be dropped.
        @(negedge clk);
        rst = 1'b1; we_i = 1'b1; waddr_i = 32'h3104; wdata_i = 32'h7777_7777;
        snoop_wr_i = 1'b1; snoop_a_i = 32'h4004;
        #1;
        total++;
        if (hit_o !== 1'b0 || data_o !== 32'h0) begin
            bad++; $display("FAIL reset_gates_output: hit=%b data=%h want hit=0 data=0", hit_o, data_o);
        end
        @(negedge clk);
        rst = 1'b0; we_i = 1'b0; snoop_wr_i = 1'b0;
        lookup(32'h3000);
        total++;
        if (hit_o !== 1'b0 || data_o !== 32'h0) begin
            bad++; $display("FAIL reset_clears_line: hit=%b data=%h want hit=0 data=0", hit_o, data_o);
        end
        lookup(32'h3104);
        total++;
        if (hit_o !== 1'b0 || data_o !== 32'h0) begin
            bad++; $display("FAIL reset_drops_fill: hit=%b data=%h want hit=0 data=0", hit_o, data_o);
        end
        lookup(32'h4008);
        total++;
        if (hit_o !== 1'b0 || data_o !== 32'h0) begin
            bad++; $display("FAIL reset_clears_other: hit=%b data=%h want hit=0 data=0", hit_o, data_o);
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_fill_hit();
        test_eviction();
        test_snoop();
        test_fill_snoop_same_edge();
        test_noncacheable();
        test_back_to_back();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
